// File: rtl/capture_replay_buffer.sv
// Captures one window of samples into block RAM on a trigger, then replays it
// as REPLAY_COUNT identical frames separated by a fixed idle gap.
module capture_replay_buffer #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int CAPTURE_LENGTH    = 1000,
  parameter int REPLAY_COUNT      = 2002,
  parameter int GAP_CYCLES        = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         trigger,
  input  logic                         sample_valid,
  input  logic [SAMPLE_DATA_WIDTH-1:0] sample_data,
  output logic                         axiov,
  output logic [SAMPLE_DATA_WIDTH-1:0] axiod,
  output logic                         frame_start,
  output logic                         busy,
  output logic                         done
);

  localparam int W  = SAMPLE_DATA_WIDTH;
  localparam int AW = (CAPTURE_LENGTH > 1) ? $clog2(CAPTURE_LENGTH) : 1;
  localparam int FW = $clog2(REPLAY_COUNT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  // FINISH drains the two-stage read pipeline of the last frame before done.
  typedef enum logic [2:0] {IDLE, CAPTURE, REPLAY, GAP, FINISH} state_t;

  state_t          state_r, state_s;
  logic [W-1:0]    ram_r [CAPTURE_LENGTH];
  logic [W-1:0]    ram_q_r;
  logic [AW-1:0]   wr_addr_r, rd_addr_r;
  logic [FW-1:0]   frame_cnt_r;
  logic [GW-1:0]   gap_cnt_r;
  logic            wr_en_s, rd_en_s, wr_last_s, rd_last_s, last_frame_s;
  logic            rd_vld_r, rd_first_r;
  logic            axiov_r, frame_start_r, busy_r, done_r;
  logic [W-1:0]    axiod_r;

  // Next-state decode plus RAM write/read enables.
  always_comb begin
    state_s      = state_r;
    wr_en_s      = 1'b0;
    rd_en_s      = 1'b0;
    wr_last_s    = (wr_addr_r == AW'(CAPTURE_LENGTH - 1));
    rd_last_s    = (rd_addr_r == AW'(CAPTURE_LENGTH - 1));
    last_frame_s = (frame_cnt_r == FW'(REPLAY_COUNT - 1));
    case (state_r)
      IDLE: begin
        if (trigger) begin
          wr_en_s = sample_valid;
          state_s = (sample_valid && wr_last_s) ? REPLAY : CAPTURE;
        end else begin
          state_s = IDLE;
        end
      end
      CAPTURE: begin
        if (sample_valid) begin
          wr_en_s = 1'b1;
          state_s = wr_last_s ? REPLAY : CAPTURE;
        end else begin
          state_s = CAPTURE;
        end
      end
      REPLAY: begin
        rd_en_s = 1'b1;
        if (rd_last_s) begin
          state_s = last_frame_s ? FINISH : GAP;
        end else begin
          state_s = REPLAY;
        end
      end
      // The read pipeline overlaps the gap, so GAP lasts exactly GAP_CYCLES.
      GAP: begin
        if (gap_cnt_r == GW'(GAP_CYCLES - 1)) begin
          state_s = REPLAY;
        end else begin
          state_s = GAP;
        end
      end
      FINISH: begin
        if (done_r) begin
          state_s = IDLE;
        end else begin
          state_s = FINISH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register and address/frame/gap counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      wr_addr_r   <= '0;
      rd_addr_r   <= '0;
      frame_cnt_r <= '0;
      gap_cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      if (wr_en_s) begin
        wr_addr_r <= wr_last_s ? '0 : wr_addr_r + 1'b1;
      end
      if (rd_en_s) begin
        rd_addr_r <= rd_last_s ? '0 : rd_addr_r + 1'b1;
      end
      if (state_r == IDLE) begin
        frame_cnt_r <= '0;
      end else if (rd_en_s && rd_last_s) begin
        frame_cnt_r <= frame_cnt_r + 1'b1;
      end
      gap_cnt_r <= (state_r == GAP && state_s == GAP) ? gap_cnt_r + 1'b1 : '0;
    end
  end

  // Sample storage; left unreset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      ram_r[wr_addr_r] <= sample_data;
    end
    ram_q_r <= ram_r[rd_addr_r];
  end

  // Output pipeline aligned with the one-cycle RAM read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_r      <= 1'b0;
      rd_first_r    <= 1'b0;
      axiov_r       <= 1'b0;
      axiod_r       <= '0;
      frame_start_r <= 1'b0;
      done_r        <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      rd_vld_r      <= rd_en_s;
      rd_first_r    <= rd_en_s && (rd_addr_r == '0);
      axiov_r       <= rd_vld_r;
      frame_start_r <= rd_vld_r && rd_first_r;
      if (rd_vld_r) begin
        axiod_r <= ram_q_r;
      end
      done_r        <= (state_r == FINISH) && !rd_vld_r && axiov_r;
      busy_r        <= (state_s != IDLE);
    end
  end

  assign axiov       = axiov_r;
  assign axiod       = axiod_r;
  assign frame_start = frame_start_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_capture_replay_buffer.sv
// Bench for capture_replay_buffer: two instances (gap 1 / gap 3) share stimulus;
// a per-instance scoreboard checks every beat, frame shape, done and busy.
module tb_capture_replay_buffer;
  localparam int W = 8, L = 4;
  localparam int RC_A = 3, G_A = 1, RC_B = 2, G_B = 3;

  logic clk = 1'b0, rst = 1'b1, trigger = 1'b0, sample_valid = 1'b0;
  logic [W-1:0] sample_data = '0;
  logic axiov_a, frame_start_a, busy_a, done_a, axiov_b, frame_start_b, busy_b, done_b;
  logic [W-1:0] axiod_a, axiod_b;

  capture_replay_buffer #(.SAMPLE_DATA_WIDTH(W), .CAPTURE_LENGTH(L), .REPLAY_COUNT(RC_A), .GAP_CYCLES(G_A)) dut_a (
    .clk(clk), .rst(rst), .trigger(trigger), .sample_valid(sample_valid), .sample_data(sample_data),
    .axiov(axiov_a), .axiod(axiod_a), .frame_start(frame_start_a), .busy(busy_a), .done(done_a));
  capture_replay_buffer #(.SAMPLE_DATA_WIDTH(W), .CAPTURE_LENGTH(L), .REPLAY_COUNT(RC_B), .GAP_CYCLES(G_B)) dut_b (
    .clk(clk), .rst(rst), .trigger(trigger), .sample_valid(sample_valid), .sample_data(sample_data),
    .axiov(axiov_b), .axiod(axiod_b), .frame_start(frame_start_b), .busy(busy_b), .done(done_b));

  always #5 clk = ~clk;

  typedef struct {
    int               ncyc;      // stimulus cycles, cycle 0 carries the trigger
    logic [7:0]       m;         // sample_valid per cycle
    logic [7:0][W-1:0] d;        // sample_data per cycle
    logic [3:0][W-1:0] e;        // expected frame contents
    int               trig_cap;  // extra trigger cycle during capture (-1 none)
    int               trig_rep;  // extra trigger delay into replay (-1 none)
  } vec_t;

  vec_t tbl[5];
  int errors = 0, checks = 0;
  logic [W:0] q_a[$], q_b[$];
  int beats[2], gaps[2], frames[2], dones[2], busy_cyc[2], first_lat[2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [W-1:0] d, input logic fs,
                     input logic dn, input logic bz);
    string p = (id == 0) ? "a" : "b";
    int rc = (id == 0) ? RC_A : RC_B;
    int g  = (id == 0) ? G_A : G_B;
    int qs = (id == 0) ? q_a.size() : q_b.size();
    logic [W:0] e;
    if (bz) busy_cyc[id]++;
    if (v) begin
      if (qs == 0) begin
        check({p, "_unexpected_beat"}, 1, 0);
      end else begin
        e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
        check({p, "_data"}, d, e[W-1:0]);
        check({p, "_frame_start"}, fs, e[W]);
      end
      if (fs && frames[id] > 0) check({p, "_gap_len"}, gaps[id], g);
      if (fs && frames[id] == 0) first_lat[id] = busy_cyc[id];
      if (fs) begin
        frames[id]++;
        beats[id] = 0;
      end
      beats[id]++;
      gaps[id] = 0;
    end else begin
      if (beats[id] != 0) begin
        check({p, "_frame_len"}, beats[id], L);
        beats[id] = 0;
      end
      if (fs) check({p, "_frame_start_no_valid"}, fs, 0);
      gaps[id]++;
    end
    if (dn) begin
      dones[id]++;
      check({p, "_done_after_last_beat"}, gaps[id], 1);
      check({p, "_frames_at_done"}, frames[id], rc);
      check({p, "_queue_empty_at_done"}, (id == 0) ? q_a.size() : q_b.size(), 0);
      check({p, "_busy_with_done"}, bz, 1);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      beats = '{0, 0};
      gaps  = '{0, 0};
    end else begin
      mon(0, axiov_a, axiod_a, frame_start_a, done_a, busy_a);
      mon(1, axiov_b, axiod_b, frame_start_b, done_b, busy_b);
    end
  end

  task automatic drive_stim(input vec_t v);
    frames = '{0, 0};
    busy_cyc = '{0, 0};
    first_lat = '{-1, -1};
    for (int f = 0; f < RC_A; f++)
      for (int k = 0; k < L; k++) q_a.push_back({k == 0, v.e[k]});
    for (int f = 0; f < RC_B; f++)
      for (int k = 0; k < L; k++) q_b.push_back({k == 0, v.e[k]});
    for (int c = 0; c < v.ncyc; c++) begin
      trigger      = (c == 0) || (c == v.trig_cap);
      sample_valid = v.m[c];
      sample_data  = v.d[c];
      @(negedge clk);
    end
    trigger = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int d0 = dones[0], d1 = dones[1], n = 0, cap = v.ncyc - 1;
    drive_stim(v);
    if (v.trig_rep >= 0) begin
      repeat (v.trig_rep) @(negedge clk);
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
    end
    while ((busy_a || busy_b) && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check({nm, "_idle_timeout"}, int'(n < 300), 1);
    check({nm, "_a_one_done"}, dones[0] - d0, 1);
    check({nm, "_b_one_done"}, dones[1] - d1, 1);
    check({nm, "_a_busy_cycles"}, busy_cyc[0], cap + RC_A * L + (RC_A - 1) * G_A + 3);
    check({nm, "_b_busy_cycles"}, busy_cyc[1], cap + RC_B * L + (RC_B - 1) * G_B + 3);
    check({nm, "_a_first_beat_latency"}, first_lat[0], cap + 3);
    check({nm, "_b_first_beat_latency"}, first_lat[1], cap + 3);
    check({nm, "_a_busy_low_after"}, busy_a, 0);
    check({nm, "_a_leftover"}, q_a.size(), 0);
    check({nm, "_b_leftover"}, q_b.size(), 0);
  endtask

  task automatic check_zero(input string nm);
    check({nm, "_axiov_a"}, axiov_a, 0);
    check({nm, "_axiod_a"}, axiod_a, 0);
    check({nm, "_frame_start_a"}, frame_start_a, 0);
    check({nm, "_busy_a"}, busy_a, 0);
    check({nm, "_done_a"}, done_a, 0);
    check({nm, "_axiov_b"}, axiov_b, 0);
    check({nm, "_axiod_b"}, axiod_b, 0);
    check({nm, "_busy_b"}, busy_b, 0);
    check({nm, "_done_b"}, done_b, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n, d0, d1;
    tbl[0] = '{5, 8'b0001_1110, {8'd0, 8'd0, 8'd0, 8'd40, 8'd30, 8'd20, 8'd10, 8'd0},
               {8'd40, 8'd30, 8'd20, 8'd10}, -1, -1};
    tbl[1] = '{8, 8'b1100_1010, {8'd8, 8'd7, 8'd0, 8'd0, 8'd6, 8'd0, 8'd5, 8'd0},
               {8'd8, 8'd7, 8'd6, 8'd5}, -1, -1};
    tbl[2] = '{4, 8'b0000_1111, {8'd0, 8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1, 8'd99},
               {8'd3, 8'd2, 8'd1, 8'd99}, -1, -1};
    tbl[3] = '{5, 8'b0001_1110, {8'd0, 8'd0, 8'd0, 8'd1, 8'd128, 8'd0, 8'd255, 8'd0},
               {8'd1, 8'd128, 8'd0, 8'd255}, 2, 3};
    tbl[4] = '{5, 8'b0001_1110, {8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
               {8'd4, 8'd3, 8'd2, 8'd1}, -1, -1};
    dones = '{0, 0};

    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_vec(tbl[0], "basic");
    run_vec(tbl[1], "stalled");
    run_vec(tbl[2], "trig_with_sample");
    run_vec(tbl[3], "ignored_trigger");

    // Asynchronous reset in the middle of the second frame of instance a.
    drive_stim(tbl[0]);
    n = 0;
    while (frames[0] < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midreplay_reached_frame2", int'(n < 100), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_zero("async_reset");
    q_a.delete();
    q_b.delete();
    d0 = dones[0];
    d1 = dones[1];
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("after_reset_no_done_a", dones[0] - d0, 0);
    check("after_reset_no_done_b", dones[1] - d1, 0);
    check("after_reset_idle_a", busy_a, 0);
    run_vec(tbl[4], "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/capture_replay_buffer.md
Name: capture_replay_buffer

Overview:
Upstream feeder for the matched-filter stage. On a trigger it captures one window of CAPTURE_LENGTH ADC samples into block RAM. It then replays that window as REPLAY_COUNT back-to-back frames on an AXI-style valid/data stream, with a fixed idle gap between frames. Each frame is one contiguous run of valid beats, so the filter sees identical data for its mean pass and every phase-shift pass. Several matched filters, one per fingerprint, can share its output.

Parameters:
SAMPLE_DATA_WIDTH, 8, bits per sample, passed through unmodified.
CAPTURE_LENGTH, 1000, samples per capture window and per replayed frame.
REPLAY_COUNT, 2002, frames replayed per capture; default covers 1 mean frame plus 2*CAPTURE_LENGTH+1 phase-shift frames.
GAP_CYCLES, 1, cycles with axiov low between consecutive frames (minimum 1).

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
trigger  in  1  start a capture; sampled only in IDLE.
sample_valid  in  1  incoming sample strobe.
sample_data  in  SAMPLE_DATA_WIDTH  incoming sample.
axiov  out  1  replay stream valid.
axiod  out  SAMPLE_DATA_WIDTH  replay stream data.
frame_start  out  1  high with the first valid beat of each frame.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse after the last beat of the last frame.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; axiov=0, axiod=0, frame_start=0, done=0, busy=0.
  - All counters cleared.
  - RAM contents are not cleared.
- Storage: single-clock RAM of depth CAPTURE_LENGTH, width SAMPLE_DATA_WIDTH. Synchronous read, 1-cycle latency; axiod/axiov are registered after it.
- Counter widths:
  - Write/read address: $clog2(CAPTURE_LENGTH).
  - Frame counter: $clog2(REPLAY_COUNT+1).
  - Gap counter: $clog2(GAP_CYCLES+1).
- IDLE:
  - trigger=1 -> CAPTURE.
  - If sample_valid=1 in that same cycle, that sample is written as sample 0.
- CAPTURE:
  - Each cycle with sample_valid=1 writes sample_data at write address, then increments the address.
  - sample_valid=0 stalls; no write, no timeout.
  - trigger is ignored.
  - The cycle that writes sample CAPTURE_LENGTH-1 transitions to REPLAY, with read address=0 and frame counter=0.
- REPLAY:
  - Issues read addresses 0..CAPTURE_LENGTH-1 on consecutive cycles, no stalls. There is no downstream backpressure.
  - axiov is high on exactly CAPTURE_LENGTH consecutive cycles. The first is 2 cycles after REPLAY entry.
  - axiod = RAM[k] on the k-th valid beat.
  - frame_start=1 on beat 0 only.
  - After the last address is issued -> GAP.
- GAP:
  - axiov=0 for exactly GAP_CYCLES cycles after the last valid beat of the frame. Frame counter increments.
  - If frame counter reaches REPLAY_COUNT: done pulses on the first cycle after the last beat, then -> IDLE.
  - Otherwise -> REPLAY at address 0. Pipeline timing keeps the inter-frame gap exactly GAP_CYCLES.
- trigger is ignored in all states except IDLE; it is not queued.
- axiod holds its last value while axiov=0.
- busy=1 from the cycle after trigger acceptance through the cycle done pulses.
- A new trigger is accepted the cycle after done.
- Reset mid-CAPTURE or mid-REPLAY aborts immediately. No done pulse; the partial frame is truncated.
- REPLAY_COUNT=1 emits one frame then done.
- Data is bit-exact; no sign interpretation in this block.

Test Plan:
- Basic capture/replay (CAPTURE_LENGTH=4, REPLAY_COUNT=3, GAP_CYCLES=1): trigger, then samples 10,20,30,40 on consecutive cycles.
  - Required: 3 frames of axiod=10,20,30,40 with axiov high 4 cycles, low 1 cycle between frames.
  - Required: frame_start on each 10; done one cycle after the final 40; busy low afterward.
- Stalled capture: samples 5,_,6,_,_,7,8 (_ = sample_valid low) -> replay frames are exactly 5,6,7,8, with no gaps inside a frame.
- Trigger with sample: trigger and sample_valid both high with data 99 in the same cycle, then 1,2,3 -> frames are 99,1,2,3.
- Ignored trigger: trigger pulsed during CAPTURE and during REPLAY -> no restart.
  - Frame count stays 3; exactly one done; busy stays high throughout.
- Async reset mid-REPLAY of frame 2: outputs zero immediately with no done.
  - A new trigger then captures 1,2,3,4 and replays it correctly.
- GAP_CYCLES=3, REPLAY_COUNT=2: exactly 3 invalid cycles between frames; total busy duration matches the computed cycle count.
